// File: rtl/iot_pkg.sv
// Shared constants for the IOTDF output serializer: word geometry, result tags, FSM states.
package iot_pkg;

  localparam int IOT_DW         = 128;
  localparam int IOT_BW         = 8;
  localparam int BYTES_PER_WORD = IOT_DW / IOT_BW;

  localparam logic [2:0] IOT_FN_GRAY2BIN = 3'b001;
  localparam logic [2:0] IOT_FN_FIR      = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_CKSUM = 2'd2
  } state_t;

endpackage

// File: rtl/iot_out_serializer_if.sv
// Result-word input and byte-stream output of the serializer, grouped as one bus.
interface iot_out_serializer_if #(
  parameter int DW = 128,
  parameter int BW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [2:0]    in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_byte;
  logic [2:0]    out_tag;
  logic          out_last;
  logic          overflow;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output out_valid, out_byte, out_tag, out_last, overflow
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  out_valid, out_byte, out_tag, out_last, overflow
  );
endinterface

// File: rtl/iot_word_fifo.sv
// Small power-of-two FIFO holding {tag, word} entries; push ignored when full, pop ignored when empty.
module iot_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 131
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // NOTE: storage has no reset; only pointers and count need a known state, and
  // an unreset array maps onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: state updates use non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/iot_out_serializer.sv
// Buffers 128-bit result words and streams them out MSB byte first under valid/ready.
// Optional: define IOT_SER_CKSUM_EN to append an XOR checksum byte to every word.
module iot_out_serializer
  import iot_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = IOT_DW,
  parameter int BW    = IOT_BW
) (
  input  logic                 clk,
  input  logic                 rst,
  iot_out_serializer_if.slave  bus
);

  localparam int NB = DW / BW;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW+2:0]  w_head;
  logic [DW-1:0]  w_head_data;
  logic [2:0]     w_head_tag;
  logic [CW-1:0]  w_count;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_more;
  logic [DW-1:0]  w_shifted;
  logic           w_idx_last;
  state_t         r_state;
  state_t         w_state_next;
  logic [IW-1:0]  r_idx;
  logic [IW-1:0]  w_idx_next;
  logic           r_overflow;
  logic           w_valid;
  logic           w_last;
  logic [BW-1:0]  w_byte;
  logic [2:0]     w_tag;

  assign w_push = bus.in_valid & ~w_full;

  iot_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW + 3)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({bus.in_tag, bus.in_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_tag  = w_head[DW+2:DW];
  assign w_head_data = w_head[DW-1:0];
  assign w_shifted   = w_head_data << (int'(r_idx) * BW);
  assign w_idx_last  = (r_idx == IW'(NB - 1));
  // Occupancy after this cycle's pop stays non-zero if another word was queued or arrives now.
  assign w_more      = (w_count > CW'(1)) | w_push;

`ifdef IOT_SER_CKSUM_EN
  logic [BW-1:0] w_cksum;
  always_comb begin
    w_cksum = '0;
    for (int k = 0; k < NB; k++) w_cksum = w_cksum ^ w_head_data[k*BW +: BW];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (bus.in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_pop        = 1'b0;
    w_valid      = 1'b0;
    w_last       = 1'b0;
    w_byte       = '0;
    w_tag        = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_next = S_SEND;
      end
      S_SEND: begin
        w_valid = 1'b1;
        w_byte  = w_shifted[DW-1 -: BW];
        w_tag   = w_head_tag;
`ifdef IOT_SER_CKSUM_EN
        if (bus.out_ready) begin
          if (w_idx_last) begin
            w_idx_next   = '0;
            w_state_next = S_CKSUM;
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end
      end
      S_CKSUM: begin
        w_valid = 1'b1;
        w_byte  = w_cksum;
        w_tag   = w_head_tag;
        w_last  = 1'b1;
        if (bus.out_ready) begin
          w_pop        = 1'b1;
          w_state_next = w_more ? S_SEND : S_IDLE;
        end
      end
`else
        w_last  = w_idx_last;
        if (bus.out_ready) begin
          if (w_idx_last) begin
            w_pop        = 1'b1;
            w_idx_next   = '0;
            w_state_next = w_more ? S_SEND : S_IDLE;
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.out_valid = w_valid;
  assign bus.out_byte  = w_byte;
  assign bus.out_tag   = w_tag;
  assign bus.out_last  = w_last;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_iot_out_serializer.sv
// Self-checking bench for iot_out_serializer: directed scenarios plus random traffic against a byte-queue model.
module tb_iot_out_serializer;
  import iot_pkg::*;

  localparam int DEPTH = 2;
  localparam int DW    = 128;
  localparam int BW    = 8;
  localparam int NB    = DW / BW;
`ifdef IOT_SER_CKSUM_EN
  localparam int NX = NB + 1;
  localparam bit CK = 1'b1;
`else
  localparam int NX = NB;
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  iot_out_serializer_if #(.DW(DW), .BW(BW)) u_if ();

  iot_out_serializer #(.DEPTH(DEPTH), .DW(DW), .BW(BW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic [2:0] tag;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   occ;
  bit   m_ovf;
  bit   pend_prev;
  bit   prev_stall;
  logic [7:0] prev_byte;
  logic [2:0] prev_tag;
  logic       prev_last;
  int   n_xfer;
  int   n_checks;
  int   n_fail;

  // Expected byte sequence of one word: MSB byte first, optional XOR byte last.
  function automatic void model_push(input logic [DW-1:0] d, input logic [2:0] t);
    logic [DW-1:0] s;
    logic [7:0]    b;
    logic [7:0]    x;
    x = 8'h00;
    for (int k = 0; k < NB; k++) begin
      s = d >> (DW - BW * (k + 1));
      b = s[7:0];
      x = x ^ b;
      exp_q.push_back('{b: b, tag: t, last: ((k == NB - 1) && !CK)});
    end
    if (CK) exp_q.push_back('{b: x, tag: t, last: 1'b1});
  endfunction

  // Monitor: samples mid-cycle, predicts the next edge from queue occupancy.
  always @(negedge clk) begin
    bit   pend_now;
    bit   acc;
    exp_t e;
    if (!rst) begin
      exp_q.delete();
      occ        = 0;
      m_ovf      = 1'b0;
      pend_prev  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      pend_now = (exp_q.size() != 0);
      n_checks++;
      if (u_if.out_valid !== (pend_now && pend_prev)) begin
        n_fail++;
        $display("FAIL mon_valid: got %b expected %b at %0t", u_if.out_valid, pend_now && pend_prev, $time);
      end
      n_checks++;
      if (u_if.overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL mon_overflow: got %b expected %b at %0t", u_if.overflow, m_ovf, $time);
      end
      if (prev_stall) begin
        n_checks++;
        if ({u_if.out_byte, u_if.out_tag, u_if.out_last} !== {prev_byte, prev_tag, prev_last}) begin
          n_fail++;
          $display("FAIL mon_hold: got %h/%0d/%b expected %h/%0d/%b at %0t", u_if.out_byte, u_if.out_tag,
                   u_if.out_last, prev_byte, prev_tag, prev_last, $time);
        end
      end
      acc = (u_if.in_valid === 1'b1) && (occ < DEPTH);
      if (u_if.in_valid === 1'b1 && !acc) m_ovf = 1'b1;
      if (u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL mon_extra_byte: got byte %h expected none at %0t", u_if.out_byte, $time);
        end else begin
          e = exp_q.pop_front();
          n_xfer++;
          if ({u_if.out_byte, u_if.out_tag, u_if.out_last} !== {e.b, e.tag, e.last}) begin
            n_fail++;
            $display("FAIL mon_byte: got %h/%0d/%b expected %h/%0d/%b at %0t", u_if.out_byte, u_if.out_tag,
                     u_if.out_last, e.b, e.tag, e.last, $time);
          end
          if (e.last) occ--;
        end
      end
      if (acc) begin
        model_push(u_if.in_data, u_if.in_tag);
        occ++;
      end
      pend_prev  = pend_now;
      prev_stall = (u_if.out_valid === 1'b1) && (u_if.out_ready !== 1'b1);
      prev_byte  = u_if.out_byte;
      prev_tag   = u_if.out_tag;
      prev_last  = u_if.out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.in_tag    = '0;
    u_if.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.in_tag    = '0;
    u_if.out_ready = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({u_if.out_valid, u_if.out_byte, u_if.out_tag, u_if.out_last, u_if.overflow} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b b=%h t=%0d l=%b o=%b expected all zero", u_if.out_valid,
               u_if.out_byte, u_if.out_tag, u_if.out_last, u_if.overflow);
    end
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (u_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got out_valid %b expected 0", u_if.out_valid);
    end
  endtask

  task automatic test_basic();
    logic [7:0] eb;
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    u_if.in_tag    = IOT_FN_GRAY2BIN;
    tick();
    u_if.in_valid = 1'b0;
    for (int k = 0; k < NX; k++) begin
      tick();
      eb = (k < NB) ? 8'(k * 17) : 8'h00;
      n_checks++;
      if ({u_if.out_valid, u_if.out_byte, u_if.out_last} !== {1'b1, eb, (k == NX - 1)}) begin
        n_fail++;
        $display("FAIL basic_byte%0d: got v=%b b=%h l=%b expected v=1 b=%h l=%b", k, u_if.out_valid,
                 u_if.out_byte, u_if.out_last, eb, (k == NX - 1));
      end
    end
    tick();
    n_checks++;
    if (u_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: got out_valid %b expected 0", u_if.out_valid);
    end
  endtask

  task automatic test_ready_toggle();
    int n0;
    n0 = n_xfer;
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = {$urandom, $urandom, $urandom, $urandom};
    u_if.in_tag    = IOT_FN_FIR;
    tick();
    u_if.in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      u_if.out_ready = (i % 2 == 0);
      tick();
    end
    n_checks++;
    if (n_xfer - n0 != NX) begin
      n_fail++;
      $display("FAIL toggle_count: got %0d transfers expected %0d", n_xfer - n0, NX);
    end
  endtask

  task automatic test_overflow();
    int n0;
    n0 = n_xfer;
    u_if.out_ready = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      u_if.in_valid = 1'b1;
      u_if.in_data  = {$urandom, $urandom, $urandom, $urandom};
      u_if.in_tag   = 3'(w);
      tick();
    end
    u_if.in_valid = 1'b0;
    tick();
    n_checks++;
    if (u_if.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b expected 1", u_if.overflow);
    end
    u_if.out_ready = 1'b1;
    repeat (3 * NX + 5) tick();
    n_checks++;
    if (n_xfer - n0 != 2 * NX) begin
      n_fail++;
      $display("FAIL ovf_words: got %0d transfers expected %0d", n_xfer - n0, 2 * NX);
    end
    n_checks++;
    if (u_if.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b expected 1", u_if.overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] b_word;
    bit            found;
    found  = 1'b0;
    b_word = {$urandom, $urandom, $urandom, $urandom};
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = {$urandom, $urandom, $urandom, $urandom};
    u_if.in_tag    = IOT_FN_GRAY2BIN;
    tick();
    u_if.in_valid = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = (u_if.out_valid === 1'b1) && (u_if.out_last === 1'b1);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL b2b_last_timeout: got no out_last expected one within 40 cycles");
    end else begin
      u_if.in_valid = 1'b1;
      u_if.in_data  = b_word;
      u_if.in_tag   = IOT_FN_FIR;
      tick();
      u_if.in_valid = 1'b0;
      n_checks++;
      if ({u_if.out_valid, u_if.out_tag, u_if.out_byte, u_if.out_last} !==
          {1'b1, IOT_FN_FIR, b_word[DW-1:DW-8], 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_first: got v=%b t=%0d b=%h l=%b expected v=1 t=%0d b=%h l=0", u_if.out_valid,
                 u_if.out_tag, u_if.out_byte, u_if.out_last, IOT_FN_FIR, b_word[DW-1:DW-8]);
      end
      repeat (NX + 3) tick();
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b1;
    u_if.in_data   = {$urandom, $urandom, $urandom, $urandom};
    u_if.in_tag    = IOT_FN_FIR;
    tick();
    u_if.in_valid = 1'b0;
    repeat (8) tick();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (u_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_valid: got %b expected 0", u_if.out_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (u_if.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_resume: got %0d valid cycles expected 0", seen);
    end
  endtask

`ifdef IOT_SER_CKSUM_EN
  task automatic test_cksum();
    logic [DW-1:0] words [2];
    logic [7:0]    exp_ck [2];
    words[0]  = {16{8'h5A}};
    words[1]  = {8'h01, 120'h0};
    exp_ck[0] = 8'h00;
    exp_ck[1] = 8'h01;
    u_if.out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      u_if.in_valid = 1'b1;
      u_if.in_data  = words[w];
      u_if.in_tag   = IOT_FN_GRAY2BIN;
      tick();
      u_if.in_valid = 1'b0;
      repeat (NX) tick();
      n_checks++;
      if ({u_if.out_valid, u_if.out_byte, u_if.out_last} !== {1'b1, exp_ck[w], 1'b1}) begin
        n_fail++;
        $display("FAIL cksum_word%0d: got v=%b b=%h l=%b expected v=1 b=%h l=1", w, u_if.out_valid,
                 u_if.out_byte, u_if.out_last, exp_ck[w]);
      end
      repeat (2) tick();
    end
  endtask
`endif

  task automatic test_random();
    int budget;
    for (int i = 0; i < 800; i++) begin
      u_if.in_valid  = ($urandom_range(0, 11) == 0);
      u_if.in_data   = {$urandom, $urandom, $urandom, $urandom};
      u_if.in_tag    = 3'($urandom);
      u_if.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    budget = 0;
    while ((exp_q.size() != 0 || u_if.out_valid === 1'b1) && budget < 200) begin
      tick();
      budget++;
    end
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d bytes outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_xfer   = 0;
    test_reset();
    test_basic();
    do_reset();
    test_ready_toggle();
    do_reset();
    test_overflow();
    do_reset();
    test_back_to_back();
    do_reset();
    test_reset_mid();
`ifdef IOT_SER_CKSUM_EN
    do_reset();
    test_cksum();
`endif
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
